microsequencer: RTL

Microprogram sequencer (Am2910-style subset) that sits directly upstream of the Am2901 bit-slice datapath. Each `cp` cycle it produces the next microinstruction address `y` for the control store. The store's pipeline register then supplies the Am2901 opcode `i`, register addresses `a`/`b` and operand `d`. The sequencer holds a microprogram counter (uPC), a register/counter (R) and a LIFO subroutine/loop stack, and implements 16 next-address instructions with conditional branching.

---
 rtl/microsequencer.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/microsequencer.sv
// -----------------------------------------------------------------------------
// microsequencer
//
// Am2910-style microprogram sequencer. Each cp cycle it selects the next
// microinstruction address y for the control store. The selection comes from
// the microprogram counter (uPC), the register/counter R, the branch operand d
// or the top of a small LIFO stack used for subroutines and loops. The choice
// is made by a 4-bit next-address instruction and an optional condition test.
//
// Parameters
//   AW     width of microaddress, R and stack entries
//   DEPTH  number of stack entries
//
// Ports
//   cp      in   clock, all state updates on the rising edge
//   reset   in   synchronous active-high reset (clears uPC, R, stack pointer)
//   i       in   next-address instruction
//   cc_n    in   condition code, active-low (0 = condition true)
//   ccen_n  in   condition enable, active-low (1 forces a pass)
//   ci      in   incrementer carry-in, uPC <= y + ci
//   rld_n   in   active-low unconditional load of R from d
//   d       in   branch address / count operand
//   y       out  next microaddress (combinational)
//   full_n  out  low while the stack holds DEPTH entries
//   pl_n    out  enable for the pipeline-register address source
//   map_n   out  enable for the mapping-PROM address source
//   vect_n  out  enable for the vector address source
// -----------------------------------------------------------------------------
module microsequencer #(
    parameter int AW    = 8,
    parameter int DEPTH = 5
) (
    input  logic          cp,
    input  logic          reset,
    input  logic [3:0]    i,
    input  logic          cc_n,
    input  logic          ccen_n,
    input  logic          ci,
    input  logic          rld_n,
    input  logic [AW-1:0] d,
    output logic [AW-1:0] y,
    output logic          full_n,
    output logic          pl_n,
    output logic          map_n,
    output logic          vect_n
);

    typedef enum logic [3:0] {
        JZ   = 4'd0,
        CJS  = 4'd1,
        JMAP = 4'd2,
        CJP  = 4'd3,
        PUSH = 4'd4,
        JSRP = 4'd5,
        CJV  = 4'd6,
        JRP  = 4'd7,
        RFCT = 4'd8,
        RPCT = 4'd9,
        CRTN = 4'd10,
        CJPP = 4'd11,
        LDCT = 4'd12,
        LOOP = 4'd13,
        CONT = 4'd14,
        TWB  = 4'd15
    } instr_t;

    // The stack pointer counts entries, so it needs to represent 0..DEPTH.
    localparam int SPW = $clog2(DEPTH + 1);
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    instr_t          instr;
    logic [AW-1:0]   upc;
    logic [AW-1:0]   r_reg;
    logic [AW-1:0]   stack [DEPTH];
    logic [SPW-1:0]  sp;

    logic            pass;
    logic            rz;
    logic            empty;
    logic            full;
    logic [AW-1:0]   tos;
    logic [SPW-1:0]  wr_idx;

    logic            push;
    logic            pop;
    logic            clear;
    logic            load_r;
    logic            dec;

    assign instr  = instr_t'(i);
    assign pass   = ccen_n | ~cc_n;
    assign rz     = (r_reg == '0);
    assign empty  = (sp == '0);
    assign full   = (sp == SP_FULL);
    assign full_n = ~full;

    // Top-of-stack read. An empty stack reads as address 0, so a return with
    // nothing pushed lands at the start of the microprogram.
    always_comb begin
        tos = '0;
        if (!empty) begin
            tos = stack[sp - SPW'(1)];
        end
    end

    // Push slot. Once the stack is full, a further push overwrites the top
    // entry in place, so the newest return address is never lost.
    always_comb begin
        wr_idx = sp;
        if (full) begin
            wr_idx = SP_FULL - SPW'(1);
        end
    end

    // Instruction decode: next address, address-source enables and the
    // stack/R side effects that take effect at the next edge. Reset overrides
    // everything so the control store sees address 0 from the pipeline source.
    always_comb begin
        y      = upc;
        pl_n   = 1'b0;
        map_n  = 1'b1;
        vect_n = 1'b1;
        push   = 1'b0;
        pop    = 1'b0;
        clear  = 1'b0;
        load_r = 1'b0;
        dec    = 1'b0;

        case (instr)
            JZ: begin
                y     = '0;
                clear = 1'b1;
            end
            CJS: begin
                if (pass) begin
                    y    = d;
                    push = 1'b1;
                end
            end
            JMAP: begin
                y     = d;
                pl_n  = 1'b1;
                map_n = 1'b0;
            end
            CJP: begin
                if (pass) begin
                    y = d;
                end
            end
            PUSH: begin
                push   = 1'b1;
                load_r = pass;
            end
            JSRP: begin
                push = 1'b1;
                y    = pass ? d : r_reg;
            end
            CJV: begin
                pl_n   = 1'b1;
                vect_n = 1'b0;
                if (pass) begin
                    y = d;
                end
            end
            JRP: begin
                y = pass ? d : r_reg;
            end
            RFCT: begin
                if (!rz) begin
                    y   = tos;
                    dec = 1'b1;
                end else begin
                    pop = 1'b1;
                end
            end
            RPCT: begin
                if (!rz) begin
                    y   = d;
                    dec = 1'b1;
                end
            end
            CRTN: begin
                if (pass) begin
                    y   = tos;
                    pop = 1'b1;
                end
            end
            CJPP: begin
                if (pass) begin
                    y   = d;
                    pop = 1'b1;
                end
            end
            LDCT: begin
                load_r = 1'b1;
            end
            LOOP: begin
                if (!pass) begin
                    y = tos;
                end else begin
                    pop = 1'b1;
                end
            end
            CONT: begin
            end
            TWB: begin
                // Two-way branch: loop back while the count runs and the
                // condition fails; the counter running out jumps to d; a
                // passing condition always falls through.
                if (!rz) begin
                    if (!pass) begin
                        y   = tos;
                        dec = 1'b1;
                    end else begin
                        pop = 1'b1;
                    end
                end else begin
                    if (!pass) begin
                        y = d;
                    end
                    pop = 1'b1;
                end
            end
            default: begin
            end
        endcase

        if (reset) begin
            y      = '0;
            pl_n   = 1'b0;
            map_n  = 1'b1;
            vect_n = 1'b1;
            push   = 1'b0;
            pop    = 1'b0;
            clear  = 1'b0;
            load_r = 1'b0;
            dec    = 1'b0;
        end
    end

    // Microprogram counter follows the selected address plus carry-in,
    // wrapping modulo 2^AW.
    always_ff @(posedge cp) begin
        if (reset) begin
            upc <= '0;
        end else begin
            upc <= y + AW'(ci);
        end
    end

    // Register/counter. The external load wins over any instruction load or
    // decrement, and the decrement stops at zero.
    always_ff @(posedge cp) begin
        if (reset) begin
            r_reg <= '0;
        end else if (!rld_n) begin
            r_reg <= d;
        end else if (load_r) begin
            r_reg <= d;
        end else if (dec && !rz) begin
            r_reg <= r_reg - AW'(1);
        end
    end

    // Stack pointer. Clear beats push/pop, push saturates at DEPTH and pop
    // saturates at zero.
    always_ff @(posedge cp) begin
        if (reset) begin
            sp <= '0;
        end else if (clear) begin
            sp <= '0;
        end else if (push) begin
            if (!full) begin
                sp <= sp + SPW'(1);
            end
        end else if (pop) begin
            if (!empty) begin
                sp <= sp - SPW'(1);
            end
        end
    end

    // Stack storage. Contents need no reset because the pointer defines what
    // is valid; the saved value is the uPC from before this edge.
    always_ff @(posedge cp) begin
        if (push) begin
            stack[wr_idx] <= upc;
        end
    end

endmodule
